// File: rtl/demod_out_pkt_pkg.sv
// Shared types and helpers for the demodulator output packetizer.
package demod_out_pkt_pkg;

  typedef enum logic [1:0] {
    FILL,
    LOAD,
    SEND
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int TLEN_W         = 16;

  function automatic logic [TLEN_W-1:0] words_to_bytes(input logic [TLEN_W-1:0] words);
    return TLEN_W'(32'(words) * BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/demod_out_pkt_ram.sv
// Simple dual-port packet buffer: synchronous write, registered read with enable.
module demod_out_pkt_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/demod_out_packetizer.sv
// Store-and-forward packetizer between the demodulator AXIS master and the RFNoC shell.
// Optional sample timestamping is enabled by defining DEMOD_OUT_PKT_TIMESTAMP_EN.
module demod_out_packetizer
  import demod_out_pkt_pkg::*;
#(
  parameter int ITEM_W  = 32,
  parameter int MAX_SPP = 256
) (
  input  logic              axis_data_clk,
  input  logic              axis_data_rst_n,
  input  logic [ITEM_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [ITEM_W-1:0] m_axis_tdata,
  output logic              m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [63:0]       m_axis_ttimestamp,
  output logic              m_axis_thas_time,
  output logic [15:0]       m_axis_tlength,
  output logic              m_axis_teov,
  output logic              m_axis_teob,
  output logic [31:0]       pkt_count
);

  localparam int ADDR_W = $clog2(MAX_SPP);
  localparam int CNT_W  = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  len_words;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  ld_idx;
  logic              teob_r;
  logic              s_hs, close_hs, adv_en, m_hs_last;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ITEM_W-1:0] rd_data_p0;
  logic              vld_p0;
  logic [ITEM_W-1:0] tdata_p1;
  logic              vld_p1, last_p1;

  assign s_axis_tready = (state == FILL) && axis_data_rst_n;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign close_hs      = s_hs && (s_axis_tlast || (wr_ptr == ADDR_W'(MAX_SPP - 1)));
  assign adv_en        = !vld_p1 || m_axis_tready;
  assign m_hs_last     = vld_p1 && m_axis_tready && last_p1;

  always_ff @(posedge axis_data_clk) begin
    if (!axis_data_rst_n) state <= FILL;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      FILL: if (close_hs) state_nxt = LOAD;
      LOAD: begin
        rd_en     = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        rd_en   = adv_en && (rd_ptr < len_words);
        rd_addr = rd_ptr[ADDR_W-1:0];
        if (m_hs_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  demod_out_pkt_ram #(
    .DATA_W (ITEM_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (axis_data_clk),
    .wr_en   (s_hs),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data_p0)
  );

  // p0: RAM read issued (vld_p0 tracks rd_data_p0); p1: output register toward the shell
  always_ff @(posedge axis_data_clk) begin
    if (!axis_data_rst_n) begin
      wr_ptr    <= '0;
      len_words <= '0;
      teob_r    <= 1'b0;
      rd_ptr    <= '0;
      ld_idx    <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (s_hs) wr_ptr <= wr_ptr + 1'b1;
      if (close_hs) begin
        len_words <= {1'b0, wr_ptr} + 1'b1;
        teob_r    <= s_axis_tlast;
      end
      if (state == LOAD) begin
        rd_ptr <= CNT_W'(1);
        ld_idx <= '0;
        vld_p0 <= 1'b1;
      end
      if (state == SEND && adv_en) begin
        vld_p1  <= vld_p0;
        last_p1 <= vld_p0 && (ld_idx == len_words - 1'b1);
        if (vld_p0) ld_idx <= ld_idx + 1'b1;
        vld_p0 <= rd_en;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
      if (m_hs_last) begin
        vld_p0    <= 1'b0;
        vld_p1    <= 1'b0;
        last_p1   <= 1'b0;
        wr_ptr    <= '0;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

  always_ff @(posedge axis_data_clk) begin
    if (state == SEND && adv_en) tdata_p1 <= rd_data_p0;
  end

  assign m_axis_tdata   = tdata_p1;
  assign m_axis_tvalid  = vld_p1;
  assign m_axis_tlast   = last_p1;
  assign m_axis_tkeep   = 1'b1;
  assign m_axis_teov    = 1'b0;
  assign m_axis_teob    = teob_r;
  assign m_axis_tlength = words_to_bytes(TLEN_W'(len_words));

`ifdef DEMOD_OUT_PKT_TIMESTAMP_EN
  logic [63:0] sample_cnt;
  logic [63:0] pkt_ts;

  always_ff @(posedge axis_data_clk) begin
    if (!axis_data_rst_n) begin
      sample_cnt <= '0;
      pkt_ts     <= '0;
    end else if (s_hs) begin
      sample_cnt <= sample_cnt + 64'd1;
      if (wr_ptr == '0) pkt_ts <= sample_cnt;
    end
  end

  assign m_axis_ttimestamp = pkt_ts;
  assign m_axis_thas_time  = (state == SEND);
`else
  assign m_axis_ttimestamp = '0;
  assign m_axis_thas_time  = 1'b0;
`endif

endmodule

// File: tb/tb_demod_out_packetizer.sv
// Directed self-checking bench for demod_out_packetizer (MAX_SPP=256).
module tb_demod_out_packetizer;

`ifdef DEMOD_OUT_PKT_TIMESTAMP_EN
  localparam logic TS_EN = 1'b1;
`else
  localparam logic TS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_ttimestamp;
  logic        m_axis_thas_time;
  logic [15:0] m_axis_tlength;
  logic        m_axis_teov;
  logic        m_axis_teob;
  logic [31:0] pkt_count;

  demod_out_packetizer #(
    .ITEM_W  (32),
    .MAX_SPP (256)
  ) dut (
    .axis_data_clk     (clk),
    .axis_data_rst_n   (rst_n),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_ttimestamp (m_axis_ttimestamp),
    .m_axis_thas_time  (m_axis_thas_time),
    .m_axis_tlength    (m_axis_tlength),
    .m_axis_teov       (m_axis_teov),
    .m_axis_teob       (m_axis_teob),
    .pkt_count         (pkt_count)
  );

  typedef struct {
    int          beats;
    logic [15:0] tlength;
    logic        teob;
    logic [63:0] ts;
    logic        thas;
    int          first_vld_cyc;
  } pkt_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          data_err = 0;
  int          sb_err = 0;
  int          stall_err = 0;
  int          rdy_err = 0;
  int          cur_beats = 0;
  int          cur_first_cyc = 0;
  logic        throttle = 1'b0;
  logic        prev_vld = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] snap_data;
  logic [15:0] snap_len;
  logic [63:0] snap_ts;
  logic        snap_last, snap_eob;
  logic [31:0] exp_q[$];
  pkt_t        pkts[$];
  pkt_t        cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ets(input logic [63:0] v);
    return TS_EN ? v : 64'd0;
  endfunction

  // Output monitor: scoreboards data, collects per-packet sidebands, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_beats  = 0;
      prev_vld   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (m_axis_tvalid && !prev_vld) cur_first_cyc = cyc;
      if (prev_stall && (m_axis_tdata !== snap_data || m_axis_tlast !== snap_last ||
          m_axis_tlength !== snap_len || m_axis_teob !== snap_eob ||
          m_axis_ttimestamp !== snap_ts || m_axis_tvalid !== 1'b1))
        stall_err++;
      if (m_axis_tvalid && s_axis_tready) rdy_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (cur_beats == 0) begin
          cur.tlength = m_axis_tlength;
          cur.teob    = m_axis_teob;
          cur.ts      = m_axis_ttimestamp;
          cur.thas    = m_axis_thas_time;
        end else if (m_axis_tlength !== cur.tlength || m_axis_teob !== cur.teob ||
                     m_axis_ttimestamp !== cur.ts || m_axis_thas_time !== cur.thas) begin
          sb_err++;
        end
        if (m_axis_tkeep !== 1'b1 || m_axis_teov !== 1'b0) sb_err++;
        if (exp_q.size() == 0) data_err++;
        else if (exp_q.pop_front() !== m_axis_tdata) data_err++;
        cur_beats++;
        if (m_axis_tlast) begin
          cur.beats         = cur_beats;
          cur.first_vld_cyc = cur_first_cyc;
          pkts.push_back(cur);
          cur_beats = 0;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      snap_data  = m_axis_tdata;
      snap_last  = m_axis_tlast;
      snap_len   = m_axis_tlength;
      snap_eob   = m_axis_teob;
      snap_ts    = m_axis_ttimestamp;
      prev_vld   = m_axis_tvalid;
    end
  end

  task automatic send_frame(input string tag, input int n, input logic [31:0] base);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 5000) begin
      s_axis_tdata  = base + acc;
      s_axis_tlast  = (acc == n - 1);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      if (s_axis_tready) begin
        exp_q.push_back(s_axis_tdata);
        last_hs_cyc = cyc + 1;
        acc++;
      end
      guard++;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk({tag, "_accepted"}, 64'(acc), 64'(n));
  endtask

  task automatic wait_pkts(input string tag, input int n);
    int guard = 0;
    while (pkts.size() < n && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk({tag, "_pkts"}, 64'(pkts.size()), 64'(n));
  endtask

  task automatic chk_pkt(input string tag, input int idx, input int beats,
                         input logic [15:0] tlen, input logic teob, input logic [63:0] ts);
    if (idx >= pkts.size()) begin
      chk({tag, "_exists"}, 64'(pkts.size()), 64'(idx + 1));
    end else begin
      chk({tag, "_beats"}, 64'(pkts[idx].beats), 64'(beats));
      chk({tag, "_tlength"}, 64'(pkts[idx].tlength), 64'(tlen));
      chk({tag, "_teob"}, 64'(pkts[idx].teob), 64'(teob));
      chk({tag, "_ts"}, pkts[idx].ts, ets(ts));
      chk({tag, "_thas"}, 64'(pkts[idx].thas), 64'(TS_EN));
    end
  endtask

  initial begin
    int p;
    int guard;
    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_teob", 64'(m_axis_teob), 64'd0);
    chk("rst_tlength", 64'(m_axis_tlength), 64'd0);
    chk("rst_ts", m_axis_ttimestamp, 64'd0);
    chk("rst_thas", 64'(m_axis_thas_time), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_tready", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;

    // 600-word frame splits into 256 + 256 + 88
    send_frame("f600", 600, 32'h1000_0000);
    wait_pkts("f600", 3);
    chk_pkt("f600_p0", 0, 256, 16'd1024, 1'b0, 64'd0);
    chk_pkt("f600_p1", 1, 256, 16'd1024, 1'b0, 64'd256);
    chk_pkt("f600_p2", 2, 88, 16'd352, 1'b1, 64'd512);
    chk("f600_data", 64'(data_err), 64'd0);
    chk("f600_sideband", 64'(sb_err), 64'd0);
    chk("f600_pkt_count", 64'(pkt_count), 64'd3);

    // 10-word frame, tready=1, latency 2 cycles from last handshake
    send_frame("f10", 10, 32'hA5A5_0000);
    wait_pkts("f10", 4);
    chk_pkt("f10", 3, 10, 16'd40, 1'b1, 64'd600);
    chk("f10_latency", 64'(pkts[3].first_vld_cyc - last_hs_cyc), 64'd2);
    chk("f10_data", 64'(data_err), 64'd0);
    chk("f10_pkt_count", 64'(pkt_count), 64'd4);

    // exactly MAX_SPP words with tlast on the last one
    send_frame("f256", 256, 32'h0BAD_0000);
    wait_pkts("f256", 5);
    chk_pkt("f256", 4, 256, 16'd1024, 1'b1, 64'd610);
    repeat (20) @(posedge clk);
    #1;
    chk("f256_no_extra", 64'(pkts.size()), 64'd5);
    chk("f256_back_to_fill", 64'(s_axis_tready), 64'd1);
    chk("f256_data", 64'(data_err), 64'd0);

    // 32-word frame under random output backpressure
    throttle = 1'b1;
    send_frame("f32", 32, 32'hC0DE_0000);
    wait_pkts("f32", 6);
    throttle = 1'b0;
    chk_pkt("f32", 5, 32, 16'd128, 1'b1, 64'd866);
    chk("f32_data", 64'(data_err), 64'd0);
    chk("f32_stall_stable", 64'(stall_err), 64'd0);
    chk("f32_in_ready_in_send", 64'(rdy_err), 64'd0);
    chk("f32_sideband", 64'(sb_err), 64'd0);
    chk("f32_pkt_count", 64'(pkt_count), 64'd6);

    // reset during SEND of a 100-word packet
    p = pkts.size();
    send_frame("f100", 100, 32'h7700_0000);
    guard = 0;
    while (cur_beats < 20 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("f100_mid_send", 64'(cur_beats >= 20), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
    chk("midrst_tready", 64'(s_axis_tready), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_tready_after", 64'(s_axis_tready), 64'd1);
    chk("midrst_no_pkt", 64'(pkts.size()), 64'(p));
    @(posedge clk);
    #1;
    send_frame("f5", 5, 32'h5500_0000);
    wait_pkts("f5", p + 1);
    chk_pkt("f5", p, 5, 16'd20, 1'b1, 64'd0);
    chk("f5_data", 64'(data_err), 64'd0);
    chk("f5_pkt_count", 64'(pkt_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demod_out_packetizer.md
Name: demod_out_packetizer

Overview:
- Sits directly downstream of the demodulator IP core, between the IP's 32-bit AXIS master and the NoC shell's s_out_axis client port.
- Store-and-forwards demodulated words into one packet buffer and emits RFNoC-ready packets carrying the sidebands the shell samples on the first beat: tlength, teob, teov, ttimestamp and thas_time.
- Closes a packet on the demodulator's TLAST (end of frame) or when MAX_SPP words have been collected.

Parameters:
- ITEM_W, 32, data word width in bits; must be 32.
- MAX_SPP, 256, maximum words per output packet; power of two, 2 to 4096.
- ADDR_W, $clog2(MAX_SPP), buffer address width; derived, not overridden.

Ports:
- axis_data_clk  in  1  single clock for the whole block.
- axis_data_rst_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  32  demodulated word from the IP core.
- s_axis_tlast  in  1  end of demodulated frame.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  packet word to the shell.
- m_axis_tkeep  out  1  always 1.
- m_axis_tlast  out  1  last word of the packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  shell ready.
- m_axis_ttimestamp  out  64  sample index of the packet's first word.
- m_axis_thas_time  out  1  timestamp valid.
- m_axis_tlength  out  16  packet payload length in bytes.
- m_axis_teov  out  1  always 0.
- m_axis_teob  out  1  packet ends a demodulator frame.
- pkt_count  out  32  packets emitted since reset; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=FILL, wr_ptr=0, sample counter=0, pkt_count=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_teob=0, m_axis_tlength=0, m_axis_ttimestamp=0, m_axis_thas_time=0.
  - s_axis_tready=0 during reset; tready=1 in the first cycle after reset deasserts.
  - A reset during SEND discards the buffered packet. No partial packet is completed.
- FILL state:
  - s_axis_tready=1 and m_axis_tvalid=0.
  - Each input handshake writes buf[wr_ptr] and increments wr_ptr.
  - On the first word of a packet, latch the sample counter as pkt_ts.
  - Close condition: s_axis_tlast=1, or wr_ptr==MAX_SPP-1, on the accepted word.
  - On close: latch len_words=wr_ptr+1, latch teob=s_axis_tlast, go to LOAD.
  - tlast landing exactly on word MAX_SPP gives one packet with teob=1.
- LOAD state (1 cycle):
  - s_axis_tready=0.
  - Issue read of address 0 to the 1-cycle-latency RAM; go to SEND.
- SEND state:
  - s_axis_tready=0.
  - m_axis_tvalid rises 2 cycles after the closing input handshake.
  - The output register advances only when !m_axis_tvalid or m_axis_tready. The read address is prefetched under the same enable, so back-to-back beats run at full rate and stalls hold data stable.
  - m_axis_tlast=1 on beat len_words-1.
  - Sidebands are held constant for the whole packet:
    - tlength=len_words*4, truncated to 16 bits; MAX_SPP≤4096 so no overflow.
    - teob=latched value, teov=0, tkeep=1.
  - On the tlast handshake: pkt_count+=1, wr_ptr=0, back to FILL. tready=1 in the next cycle.
- Sample counter:
  - 64-bit; increments by 1 per accepted input word.
  - Wraps at 2^64.
- Throughput: no overlap between fill and drain. The input is backpressured for len_words+2 cycles per packet at minimum.

Optional Feature:
- Macro: DEMOD_OUT_PKT_TIMESTAMP_EN.
- Defined:
  - The 64-bit sample counter is instantiated.
  - m_axis_thas_time=1 in SEND.
  - m_axis_ttimestamp=pkt_ts.
- Undefined:
  - No counter logic.
  - m_axis_thas_time=0 and m_axis_ttimestamp=0 at all times.

Decomposition:
- Package demod_out_pkt_pkg:
  - state enum (FILL, LOAD, SEND).
  - BYTES_PER_WORD=4.
  - TLEN_W=16.
  - function words_to_bytes.
- Sub-module demod_out_pkt_ram:
  - simple dual-port, 2^ADDR_W x 32.
  - synchronous write; registered read with read enable.

Test Plan:
- Frame of 10 words, tlast on word 10, m_tready=1:
  - one packet, tlength=40, teob=1, data matches.
  - first m_tvalid exactly 2 cycles after the last input handshake.
- 600-word frame, MAX_SPP=256:
  - packets of 256, 256, 88 words; tlength=1024, 1024, 352; teob=0, 0, 1.
  - with TIMESTAMP_EN: ttimestamp=0, 256, 512.
- Exactly 256 words with tlast on word 256:
  - single packet, tlength=1024, teob=1; no empty follow-on packet.
- Random m_tready throttling (~50%) on a 32-word packet:
  - tdata and all sidebands stable while tvalid=1 and tready=0.
  - no lost or duplicated words; s_axis_tready=0 throughout SEND.
- Assert rst_n=0 for 1 cycle mid-SEND of a 100-word packet:
  - the next cycle has m_tvalid=0 and pkt_count=0.
  - a fresh 5-word frame then emits tlength=20, ttimestamp=0.
- Build without DEMOD_OUT_PKT_TIMESTAMP_EN, run the 600-word frame:
  - thas_time=0 and ttimestamp=0 on every beat.
